// File: rtl/aes_pkg.sv
// AES inverse S-box support: Canright tower-field helpers, basis matrices, FSM states.
// Purely combinational functions; no latency, no flow control.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } inv_sb_state_e;

  // Row 0 is the most significant byte.
  localparam logic [63:0] S2X = 64'h8c79_05eb_1204_5153;
  localparam logic [63:0] X2A = 64'h6478_6e8c_6829_de60;

  function automatic logic [7:0] aes_mvm(input logic [7:0] vec_b, input logic [63:0] mat);
    logic [7:0] vec_c;
    vec_c = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        vec_c[i] = vec_c[i] ^ (mat[8*(7-j)+i] & vec_b[7-j]);
      end
    end
    return vec_c;
  endfunction

  function automatic logic [1:0] aes_mul_gf2p2(input logic [1:0] g, input logic [1:0] d);
    logic [1:0] f;
    logic       a, b, c;
    a    = g[1] & d[1];
    b    = (^g) & (^d);
    c    = g[0] & d[0];
    f[1] = a ^ b;
    f[0] = c ^ b;
    return f;
  endfunction

  function automatic logic [1:0] aes_scale_omega2_gf2p2(input logic [1:0] g);
    return {g[0], g[1] ^ g[0]};
  endfunction

  function automatic logic [1:0] aes_scale_omega_gf2p2(input logic [1:0] g);
    return {g[1] ^ g[0], g[1]};
  endfunction

  function automatic logic [1:0] aes_square_gf2p2(input logic [1:0] g);
    return {g[0], g[1]};
  endfunction

  function automatic logic [3:0] aes_mul_gf2p4(input logic [3:0] gamma, input logic [3:0] delta);
    logic [1:0] a, b, c;
    a = aes_mul_gf2p2(gamma[3:2], delta[3:2]);
    b = aes_mul_gf2p2(gamma[3:2] ^ gamma[1:0], delta[3:2] ^ delta[1:0]);
    c = aes_mul_gf2p2(gamma[1:0], delta[1:0]);
    return {a ^ aes_scale_omega2_gf2p2(b), c ^ aes_scale_omega2_gf2p2(b)};
  endfunction

  function automatic logic [3:0] aes_square_scale_gf2p4_gf2p2(input logic [3:0] gamma);
    logic [1:0] a, b;
    a = gamma[3:2] ^ gamma[1:0];
    b = aes_square_gf2p2(gamma[1:0]);
    return {aes_square_gf2p2(a), aes_scale_omega_gf2p2(b)};
  endfunction

  function automatic logic [3:0] aes_inverse_gf2p4(input logic [3:0] gamma);
    logic [1:0] a, b, c, d;
    a = gamma[3:2] ^ gamma[1:0];
    b = aes_mul_gf2p2(gamma[3:2], gamma[1:0]);
    c = aes_scale_omega2_gf2p2(aes_square_gf2p2(a));
    d = aes_square_gf2p2(c ^ b);
    return {aes_mul_gf2p2(d, gamma[1:0]), aes_mul_gf2p2(d, gamma[3:2])};
  endfunction

  // Zero maps to zero without special casing.
  function automatic logic [7:0] aes_inverse_gf2p8(input logic [7:0] gamma);
    logic [3:0] a, b, c, d;
    a = gamma[7:4] ^ gamma[3:0];
    b = aes_mul_gf2p4(gamma[7:4], gamma[3:0]);
    c = aes_square_scale_gf2p4_gf2p2(a);
    d = aes_inverse_gf2p4(c ^ b);
    return {aes_mul_gf2p4(d, gamma[3:0]), aes_mul_gf2p4(d, gamma[7:4])};
  endfunction

endpackage

// File: rtl/aes_inv_sbox_canright.sv
// Inverse AES S-box, Canright normal-basis construction.
// Combinational, zero latency, no flow control.
module aes_inv_sbox_canright
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] data_x;
  logic [7:0] inv_x;

  // Inverse affine is folded into S2X, so only the constant is stripped first.
  assign data_x = aes_mvm(data_i ^ 8'h63, S2X);
  assign inv_x  = aes_inverse_gf2p8(data_x);
  assign data_o = aes_mvm(inv_x, X2A);

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative InvSubBytes: NumSbox bytes per cycle, result valid 16/NumSbox+1 cycles after accept.
// One block in flight; result held in DONE until out_ready_i, flush_i aborts from any state.
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NumSbox = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o
);

  localparam int N    = 16 / NumSbox;
  localparam int CntW = (N > 1) ? $clog2(N) : 1;
  localparam int GrpW = NumSbox * 8;

  inv_sb_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [127:0]    buf_q;
  logic [127:0]    buf_upd;
  logic            out_valid_q;
  logic [GrpW-1:0] sb_in;
  logic [GrpW-1:0] sb_out;

  for (genvar i = 0; i < NumSbox; i++) begin : g_sbox
    aes_inv_sbox_canright u_sbox (
      .data_i (sb_in[i*8 +: 8]),
      .data_o (sb_out[i*8 +: 8])
    );
  end

  // Compare-based group select keeps every slice index static.
  always_comb begin
    sb_in   = '0;
    buf_upd = buf_q;
    for (int g = 0; g < N; g++) begin
      if (cnt_q == CntW'(g)) begin
        sb_in                   = buf_q[g*GrpW +: GrpW];
        buf_upd[g*GrpW +: GrpW] = sb_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = BUSY;
      BUSY:    if (cnt_q == CntW'(N - 1)) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
      if (flush_i) begin
        cnt_q <= '0;
        buf_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid_i) begin
              buf_q <= in_data_i;
              cnt_q <= '0;
            end
          end
          BUSY: begin
            buf_q <= buf_upd;
            if (cnt_q != CntW'(N - 1)) cnt_q <= cnt_q + CntW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = buf_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for aes_inv_sub_bytes_seq across NumSbox = 4,1,2,8,16 driven by shared stimulus.
// Each instance has its own cycle-level model built on a GF(2^8) arithmetic inverse S-box table.
module tb_aes_inv_sub_bytes_seq;

  localparam int NDUT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic [NDUT-1:0] in_ready_w;
  logic [NDUT-1:0] out_valid_w;
  logic [127:0] out_data_w [NDUT];

  int total = 0;
  int bad = 0;
  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int ns, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ns=%0d got=%h exp=%h", nm, ns, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input int ns, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s ns=%0d got=%b exp=%b", nm, ns, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] r, b;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tbl[d[8*k +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int NS = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
    localparam int NG = 16 / NS;

    aes_inv_sub_bytes_seq #(.NumSbox(NS)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready_w[g]),
      .in_data_i   (in_data),
      .flush_i     (flush),
      .out_valid_o (out_valid_w[g]),
      .out_ready_i (out_ready),
      .out_data_o  (out_data_w[g])
    );

    // Model: a block is in flight for NG processing cycles, then presented until taken.
    bit           busy = 1'b0;
    int           age = 0;
    logic [127:0] exp_dat = '0;
    bit           e_valid;

    always @(negedge clk) begin
      if (rst) begin
        busy = 1'b0;
        chk1("rst_in_ready", NS, in_ready_w[g], 1'b1);
        chk1("rst_out_valid", NS, out_valid_w[g], 1'b0);
        chk("rst_out_data", NS, out_data_w[g], '0);
      end else begin
        if (busy) age++;
        e_valid = busy && (age >= NG + 1);
        chk1("in_ready", NS, in_ready_w[g], !busy);
        chk1("out_valid", NS, out_valid_w[g], e_valid);
        if (e_valid) chk("out_data", NS, out_data_w[g], exp_dat);
        if (flush) busy = 1'b0;
        else if (!busy) begin
          if (in_valid) begin
            busy    = 1'b1;
            age     = 0;
            exp_dat = ref_inv(in_data);
          end
        end else if (e_valid && out_ready) busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while (!(&in_ready_w) && n < 200) begin
      tick();
      n++;
    end
    if (!(&in_ready_w)) chk("idle_timeout", 0, 128'(in_ready_w), '1);
  endtask

  task automatic send(input logic [127:0] d);
    wait_all_idle();
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after send(): returns the cycle offset at which DUT0 raised out_valid.
  task automatic wait_dut0(output int lat);
    lat = 1;
    while (!out_valid_w[0] && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat;
    logic [127:0] d;
    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);
    chk("ref_63", 0, 128'(inv_tbl[8'h63]), 128'h00);
    chk("ref_7c", 0, 128'(inv_tbl[8'h7c]), 128'h01);
    chk("ref_16", 0, 128'(inv_tbl[8'h16]), 128'hff);
    chk("ref_ed", 0, 128'(inv_tbl[8'hed]), 128'h53);
    chk("ref_00", 0, 128'(inv_tbl[8'h00]), 128'h52);

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Known bytes plus exact latency and release on DUT0.
    d = rnd128();
    d[39:0] = 40'h00_ed_16_7c_63;
    send(d);
    wait_dut0(lat);
    chk("latency_ns4", 4, 128'(lat), 128'd5);
    chk("known_bytes", 4, 128'(out_data_w[0][39:0]), 128'h52_53_ff_01_00);
    tick();
    chk1("valid_fall", 4, out_valid_w[0], 1'b0);
    chk1("ready_back", 4, in_ready_w[0], 1'b1);

    // Every byte value once.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * b + k);
      send(d);
    end

    // Held result with ignored input pulses.
    wait_all_idle();
    out_ready = 1'b0;
    d = rnd128();
    send(d);
    for (int c = 0; c < 25; c++) begin
      in_valid = (c % 3 == 0);
      in_data  = rnd128();
      tick();
    end
    in_valid = 1'b0;
    chk("held_data", 4, out_data_w[0], ref_inv(d));
    out_ready = 1'b1;
    tick();
    chk1("held_release", 4, out_valid_w[0], 1'b0);

    // Flush in DUT0's second processing cycle, then a clean block.
    send(rnd128());
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("flush_idle", 4, in_ready_w[0], 1'b1);
    repeat (10) tick();
    send(rnd128());

    // Asynchronous reset between edges while busy.
    send(rnd128());
    tick();
    #1 rst = 1'b1;
    #1;
    chk1("arst_in_ready", 4, in_ready_w[0], 1'b1);
    chk1("arst_out_valid", 4, out_valid_w[0], 1'b0);
    chk("arst_out_data", 4, out_data_w[0], '0);
    tick();
    rst = 1'b0;
    d = rnd128();
    send(d);
    wait_dut0(lat);
    chk("post_rst_data", 4, out_data_w[0], ref_inv(d));

    // Random traffic with backpressure and occasional flush.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = rnd128();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    wait_all_idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_sub_bytes_seq.md
# aes_inv_sub_bytes_seq

Iterative InvSubBytes engine for the AES decryption datapath. It accepts one 128-bit state over a valid/ready handshake and applies the inverse AES S-box to all 16 bytes, `NumSbox` bytes per cycle. It returns the transformed state over a second valid/ready handshake. It is the decrypt-direction counterpart of the forward Canright S-box and trades latency for area by time-multiplexing a small number of inverse S-box instances.

## Interface
- `NumSbox`, default 4: inverse S-box instances; legal values are 1, 2, 4, 8 and 16; the number of processing cycles is N = 16/NumSbox.
- `clk_i`  in  1  the only clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `in_valid_i`  in  1  input state valid.
- `in_ready_o`  out  1  engine can accept a state.
- `in_data_i`  in  128  input state; byte k = bits [8k+7:8k].
- `flush_i`  in  1  synchronous abort; returns the engine to IDLE.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `out_data_o`  out  128  transformed state; byte k = InvSbox(input byte k).

## Operation
- Per-byte function (combinational, in sub-module), in this order:
  - XOR the input byte with 8'h63.
  - Multiply by S2X (inverse affine, then A-basis to X-basis).
  - Canright GF(2^8) inversion in normal basis X (0 maps to 0).
  - Multiply by X2A (X-basis back to A-basis). No output constant.
- FSM states are IDLE, BUSY and DONE. The reset state is IDLE.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`&`in_ready_o`: capture `in_data_i` into a 128-bit buffer, clear `cnt`, go to BUSY.
- BUSY:
  - Each cycle, replace bytes [cnt·NumSbox … cnt·NumSbox+NumSbox−1] of the buffer in place with their inverse S-box values.
  - If `cnt`==N−1, go to DONE; otherwise increment `cnt`.
- DONE:
  - `out_valid_o`=1.
  - On `out_ready_i`, go to IDLE.
  - `out_data_o` and `out_valid_o` hold stable while `out_ready_i`=0.
- `cnt` width is $clog2(N) bits, minimum 1. It wraps only through a fresh accept.
- `flush_i`:
  - In any state, go to IDLE next cycle, clear `cnt`, zero the buffer.
  - Flush takes priority over an accept or output handshake in the same cycle.
  - A DONE result dropped by flush is never presented.
- Input handshake outside IDLE: `in_valid_i` is ignored in BUSY and DONE, and `in_data_i` is not sampled. There is no overlap of consecutive blocks.
- When `out_valid_o`=0, `out_data_o` is the buffer contents. It is not guaranteed meaningful and must not be checked.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, buffer 0, `cnt` 0, state IDLE.
- Latency: accept in cycle t, `out_valid_o` high from cycle t+N+1.
  - Default NumSbox=4: accept at t, DONE at t+5.
  - NumSbox=16: one BUSY cycle, DONE at t+2.
- Throughput: one state every N+2 cycles when `out_ready_i` is tied high. The cycles are the accept cycle, N BUSY cycles, and the DONE/handshake cycle. IDLE re-accepts in the cycle after the output handshake.
- Reset asserted mid-operation immediately forces the reset values. Processing resumes only via a new accept after reset deasserts.
- All outputs are registered except `in_ready_o`, which decodes from the state register (no combinational input-to-output paths).

## Structure
- `aes_pkg` holds:
  - The basis matrices S2X = {8c,79,05,eb,12,04,51,53} and X2A = {64,78,6e,8c,68,29,de,60}, in the same row ordering as the forward S-box's A2X/X2S.
  - The GF(2^2)/GF(2^4)/GF(2^8) Canright helper functions, shared with the forward S-box.
  - The FSM state enum `inv_sb_state_e`.
- Sub-module `aes_inv_sbox_canright`: 8-bit in, 8-bit out, purely combinational. It is instantiated NumSbox times via generate.
- Top level contains only the FSM, counter, buffer and the byte-select/write-back muxing.

## Test plan
- Known bytes, NumSbox=4: `in_data_i` bytes {63,7c,16,ed, …} -> output bytes {00,01,ff,53, …}. Also 8'h00 -> 8'h52. Check all 256 values over 16 blocks against a reference table.
- Latency/handshake: accept at cycle t with `out_ready_i`=1 -> `out_valid_o` rises exactly at t+5 and falls at t+6; `in_ready_o` is 0 from t+1 through t+5.
- Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE -> `out_data_o` and `out_valid_o` stable; `in_valid_i` pulses are ignored and the next result equals the held state.
- Flush: assert `flush_i` at the second BUSY cycle -> IDLE next cycle, `out_valid_o` never rises for that block, and the following block's output is correct.
- Async reset: assert `rst_i` mid-BUSY between clock edges -> outputs take their reset values immediately, then normal operation resumes after deassertion.
- Parameter sweep: NumSbox ∈ {1,2,8,16} with random states -> matches the reference model, and latency equals 16/NumSbox+1 cycles.
